// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider (div/divu).
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ma;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, ma} : '0);
  assign mul_nxt = {msum, acc[WIDTH-1:1]};
  assign prod    = neg_q ? -acc : acc;

`ifdef MDU_DIV_EN
  logic               is_div;
  logic               neg_r;
  logic               bz;
  logic [WIDTH-1:0]   mb;
  logic               ge;
  logic [WIDTH-1:0]   sub;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign accept  = start;
  // the shifted partial remainder is WIDTH+1 bits; the difference fits WIDTH
  assign ge      = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, mb};
  assign sub     = acc[2*WIDTH-2:WIDTH-1] - mb;
  assign div_nxt = ge ? {sub, acc[WIDTH-2:0], 1'b1}
                      : {acc[2*WIDTH-2:0], 1'b0};
  assign quot    = acc[WIDTH-1:0];
  assign rem     = acc[2*WIDTH-1:WIDTH];
`else
  assign accept  = start & ~op[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ma     <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      bz     <= 1'b0;
      mb     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            ma    <= a_mag;
            neg_q <= a_neg ^ b_neg;
            acc   <= {{WIDTH{1'b0}}, b_mag};
`ifdef MDU_DIV_EN
            is_div <= op[1];
            neg_r  <= a_neg;
            bz     <= (b == '0);
            mb     <= b_mag;
            if (op[1]) acc <= {{WIDTH{1'b0}}, a_mag};
`endif
          end
        end
        RUN: begin
          acc <= mul_nxt;
`ifdef MDU_DIV_EN
          if (is_div) acc <= div_nxt;
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= prod;
`ifdef MDU_DIV_EN
          // divide by zero keeps HI = a and forces an all-ones quotient
          if (is_div) begin
            hi <= neg_r ? -rem : rem;
            lo <= bz ? '1 : (neg_q ? -quot : quot);
          end
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo.
// Divide vectors run when MDU_DIV_EN is defined; otherwise div is checked as ignored.
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic poke,
                        output int lat, output int bcnt);
    logic [31:0] hsave;
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    hsave = hi;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (poke && lat == 4) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      tick();
      lat++;
      if (poke && lat == 5) begin
        start = 1'b0; hi_we = 1'b0;
        chk("hi_we_busy", {32'h0, hi}, {32'h0, hsave});
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic vec(input string tag, input logic [1:0] o,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic poke, input logic [31:0] ehi,
                     input logic [31:0] elo);
    int lat;
    int bcnt;
    run_op(o, av, bv, poke, lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bcnt), 64'd33);
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    tick();
    chk({tag, "_pulse"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    int seen;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1;
    chk("rst_out", {30'h0, busy, done, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    vec("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0,
        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    vec("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
        32'hFFFF_FFFE, 32'h0000_0001);
    vec("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0,
        32'h4000_0000, 32'h0);
    vec("ignore", 2'b01, 32'd7, 32'd8, 1'b1, 32'h0, 32'd56);

`ifdef MDU_DIV_EN
    vec("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    vec("div_pn", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0,
        32'd1, 32'hFFFF_FFFD);
    vec("divu_z", 2'b11, 32'd100, 32'd0, 1'b0,
        32'd100, 32'hFFFF_FFFF);
    vec("div_z", 2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0,
        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    vec("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
        32'h0, 32'h8000_0000);
    vec("divu", 2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0,
        32'd15, 32'h0FFF_FFFF);
`else
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd5;
    tick();
    start = 1'b0;
    chk("nodiv_busy", {63'h0, busy}, 64'h0);
    seen = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("nodiv_quiet", 64'(seen), 64'h0);
    chk("nodiv_hilo", {hi, lo}, {32'h0, 32'd56});
`endif

    lo_we = 1'b1; wdata = 32'h5555_AAAA;
    tick();
    lo_we = 1'b0;
    chk("mtlo", {32'h0, lo}, 64'h5555_AAAA);

    hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    chk("mthi", {32'h0, hi}, 64'h1234);

    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) seen++;
    end
    chk("rst_busy_pre", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_flags", {62'h0, busy, done}, 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("rst_no_done", 64'(seen), 64'h0);
    chk("rst_post_hilo", {hi, lo}, 64'h0);

    vec("after_rst", 2'b01, 32'd5, 32'd6, 1'b0, 32'h0, 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
